// File: rtl/sc_spi_pkg.sv
// Shared definitions for the SPI serial-clock generator.
package sc_spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PH1  = 2'd1,
    ST_PH2  = 2'd2
  } state_t;

  localparam int CPOL_BIT = 1;
  localparam int CPHA_BIT = 0;
  localparam int DIV_MIN  = 2;

endpackage

// File: rtl/sc_spi_phase_timer.sv
// Loadable down-counter; tc is high while the count sits at zero.
module sc_spi_phase_timer
  import sc_spi_pkg::*;
#(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [DIV_W-1:0] load_val,
  output logic             tc
);

  logic [DIV_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (load)
      cnt <= load_val;
    else if (cnt != '0)
      cnt <= cnt - DIV_W'(1);
  end

  assign tc = (cnt == '0);

endmodule

// File: rtl/sc_spi_sclkgen.sv
// SPI serial-clock burst generator with CPOL/CPHA support and
// SRCCLK-aligned shift/sample strobes.
module sc_spi_sclkgen
  import sc_spi_pkg::*;
#(
  parameter int DIV_W = 8,
  parameter int CNT_W = 6
) (
  input  logic             SRCCLK,
  input  logic             SYSRST,
  input  logic             CLK_START,
  input  logic             CLK_STOP,
  input  logic [DIV_W-1:0] CLK_CLKDR,
  input  logic [1:0]       CLK_MODE,
  input  logic [CNT_W-1:0] CLK_NCYC,
  output logic             SPICLK,
  output logic             SHIFT_STB,
  output logic             SAMPLE_STB,
  output logic             BUSY,
  output logic             DONE
);

  state_t           state, state_nxt;
  logic [DIV_W-1:0] div_q, div_in, half_q, half_in, load_val;
  logic [CNT_W-1:0] cyc_q, cyc_nxt;
  logic             cpol_q, cpha_q, latch_en;
  logic             ph_load, ph_tc;
  logic             spiclk_nxt, shift_nxt, sample_nxt, busy_nxt, done_nxt;

  // Divider values below the minimum run as the minimum period.
  assign div_in  = (CLK_CLKDR < DIV_W'(DIV_MIN)) ? DIV_W'(DIV_MIN) : CLK_CLKDR;
  assign half_in = div_in >> 1;
  assign half_q  = div_q >> 1;

  sc_spi_phase_timer #(.DIV_W(DIV_W)) u_phase_timer (
    .clk      (SRCCLK),
    .rst      (SYSRST),
    .load     (ph_load),
    .load_val (load_val),
    .tc       (ph_tc)
  );

  always_comb begin
    state_nxt  = state;
    latch_en   = 1'b0;
    ph_load    = 1'b0;
    load_val   = '0;
    cyc_nxt    = cyc_q;
    spiclk_nxt = SPICLK;
    shift_nxt  = 1'b0;
    sample_nxt = 1'b0;
    busy_nxt   = BUSY;
    done_nxt   = 1'b0;
    case (state)
      ST_IDLE: begin
        spiclk_nxt = CLK_MODE[CPOL_BIT];
        busy_nxt   = 1'b0;
        if (CLK_START && !CLK_STOP) begin
          state_nxt  = ST_PH1;
          latch_en   = 1'b1;
          cyc_nxt    = CLK_NCYC;
          ph_load    = 1'b1;
          load_val   = half_in - DIV_W'(1);
          spiclk_nxt = ~CLK_MODE[CPOL_BIT];
          busy_nxt   = 1'b1;
          shift_nxt  = CLK_MODE[CPHA_BIT];
          sample_nxt = ~CLK_MODE[CPHA_BIT];
        end
      end
      ST_PH1: begin
        if (CLK_STOP) begin
          state_nxt  = ST_IDLE;
          spiclk_nxt = cpol_q;
          busy_nxt   = 1'b0;
        end else if (ph_tc) begin
          state_nxt  = ST_PH2;
          ph_load    = 1'b1;
          load_val   = div_q - half_q - DIV_W'(1);
          spiclk_nxt = cpol_q;
          sample_nxt = cpha_q;
          // With CPHA=0 the final trailing edge has no bit left to launch.
          shift_nxt  = ~cpha_q && (cyc_q != '0);
        end
      end
      ST_PH2: begin
        if (CLK_STOP) begin
          state_nxt  = ST_IDLE;
          spiclk_nxt = cpol_q;
          busy_nxt   = 1'b0;
        end else if (ph_tc) begin
          if (cyc_q == '0) begin
            state_nxt  = ST_IDLE;
            spiclk_nxt = cpol_q;
            busy_nxt   = 1'b0;
            done_nxt   = 1'b1;
          end else begin
            state_nxt  = ST_PH1;
            cyc_nxt    = cyc_q - CNT_W'(1);
            ph_load    = 1'b1;
            load_val   = half_q - DIV_W'(1);
            spiclk_nxt = ~cpol_q;
            shift_nxt  = cpha_q;
            sample_nxt = ~cpha_q;
          end
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge SRCCLK or posedge SYSRST) begin
    if (SYSRST) begin
      state      <= ST_IDLE;
      div_q      <= '0;
      cpol_q     <= 1'b0;
      cpha_q     <= 1'b0;
      cyc_q      <= '0;
      SPICLK     <= 1'b0;
      SHIFT_STB  <= 1'b0;
      SAMPLE_STB <= 1'b0;
      BUSY       <= 1'b0;
      DONE       <= 1'b0;
    end else begin
      state      <= state_nxt;
      cyc_q      <= cyc_nxt;
      SPICLK     <= spiclk_nxt;
      SHIFT_STB  <= shift_nxt;
      SAMPLE_STB <= sample_nxt;
      BUSY       <= busy_nxt;
      DONE       <= done_nxt;
      if (latch_en) begin
        div_q  <= div_in;
        cpol_q <= CLK_MODE[CPOL_BIT];
        cpha_q <= CLK_MODE[CPHA_BIT];
      end
    end
  end

endmodule

// File: tb/tb_sc_spi_sclkgen.sv
// Directed bench for sc_spi_sclkgen: vector table of bursts plus
// hand sequences for stop, start collisions and mid-burst reset.
module tb_sc_spi_sclkgen;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, stop;
  logic [7:0] clkdr;
  logic [1:0] mode;
  logic [5:0] ncyc;
  logic       spiclk, shift_stb, sample_stb, busy, done;

  int nvec  = 0;
  int nfail = 0;

  typedef struct {
    logic [1:0] mode;
    logic [7:0] clkdr;
    logic [5:0] ncyc;
    int         busy;
    int         sample;
    int         shift;
    int         done;
    int         active;
  } vec_t;

  vec_t vecs [7];

  sc_spi_sclkgen #(.DIV_W(8), .CNT_W(6)) dut (
    .SRCCLK     (clk),
    .SYSRST     (rst),
    .CLK_START  (start),
    .CLK_STOP   (stop),
    .CLK_CLKDR  (clkdr),
    .CLK_MODE   (mode),
    .CLK_NCYC   (ncyc),
    .SPICLK     (spiclk),
    .SHIFT_STB  (shift_stb),
    .SAMPLE_STB (sample_stb),
    .BUSY       (busy),
    .DONE       (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Starts a burst at the current negedge and follows it to the DONE cycle.
  task automatic run_burst(input vec_t v);
    int  b = 0, s = 0, sh = 0, d = 0, a = 0;
    bit  ended = 0;
    logic cpol;
    cpol  = v.mode[1];
    start = 1'b1;
    mode  = v.mode;
    clkdr = v.clkdr;
    ncyc  = v.ncyc;
    @(negedge clk);
    start = 1'b0;
    chk("first_busy", busy, 1);
    chk("first_clk", spiclk, !cpol);
    chk("first_stb", {shift_stb, sample_stb}, v.mode[0] ? 2 : 1);
    mode  = ~v.mode;
    clkdr = 8'd9;
    ncyc  = 6'd3;
    for (int c = 0; c < 3000; c++) begin
      if (busy) begin
        b++;
        if (spiclk != cpol) a++;
      end
      s  += int'(sample_stb);
      sh += int'(shift_stb);
      d  += int'(done);
      if (!busy) begin
        ended = 1;
        break;
      end
      @(negedge clk);
    end
    chk("burst_end_seen", int'(ended), 1);
    chk("busy_cycles", b, v.busy);
    chk("sample_count", s, v.sample);
    chk("shift_count", sh, v.shift);
    chk("done_count", d, v.done);
    chk("active_cycles", a, v.active);
    chk("done_clk", spiclk, cpol);
    mode  = v.mode;
    clkdr = v.clkdr;
    ncyc  = v.ncyc;
  endtask

  initial begin
    vecs[0] = '{2'b00, 8'd4,   6'd7,  32,  8,  7, 1, 16};
    vecs[1] = '{2'b11, 8'd5,   6'd2,  15,  3,  3, 1, 6};
    vecs[2] = '{2'b01, 8'd0,   6'd0,  2,   1,  1, 1, 1};
    vecs[3] = '{2'b01, 8'd1,   6'd0,  2,   1,  1, 1, 1};
    vecs[4] = '{2'b10, 8'd3,   6'd1,  6,   2,  1, 1, 2};
    vecs[5] = '{2'b00, 8'd255, 6'd0,  255, 1,  0, 1, 127};
    vecs[6] = '{2'b01, 8'd2,   6'd63, 128, 64, 64, 1, 64};

    rst   = 1'b1;
    start = 1'b0;
    stop  = 1'b0;
    clkdr = 8'd4;
    mode  = 2'b10;
    ncyc  = 6'd0;
    #3;
    chk("reset_outputs_async", {spiclk, shift_stb, sample_stb, busy, done}, 0);
    repeat (2) @(negedge clk);
    chk("reset_outputs_held", {spiclk, shift_stb, sample_stb, busy, done}, 0);
    rst = 1'b0;
    #1 chk("release_clk_before_edge", spiclk, 0);
    @(negedge clk);
    chk("release_clk_cpol", spiclk, 1);
    mode = 2'b00;
    @(negedge clk);

    // Bursts run back to back: each starts in the previous DONE cycle.
    for (int i = 0; i < 7; i++) run_burst(vecs[i]);

    // Abort in the second PH1 cycle of the third SPI cycle.
    @(negedge clk);
    begin
      int s = 0, sh = 0, b = 0;
      mode  = 2'b10;
      clkdr = 8'd6;
      ncyc  = 6'd7;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int c = 0; c < 14; c++) begin
        if (c > 0) @(negedge clk);
        s  += int'(sample_stb);
        sh += int'(shift_stb);
        b  += int'(busy);
      end
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      chk("stop_busy", busy, 0);
      chk("stop_clk", spiclk, 1);
      chk("stop_done", done, 0);
      chk("stop_stb", {shift_stb, sample_stb}, 0);
      chk("stop_pre_samples", s, 3);
      chk("stop_pre_shifts", sh, 2);
      chk("stop_pre_busy", b, 14);
      @(negedge clk);
      chk("stop_no_late_done", {busy, done}, 0);
    end

    // START and STOP together, then a START while busy.
    begin
      int b = 0, d = 0;
      mode  = 2'b00;
      clkdr = 8'd4;
      ncyc  = 6'd1;
      start = 1'b1;
      stop  = 1'b1;
      @(negedge clk);
      start = 1'b0;
      stop  = 1'b0;
      chk("collide_busy", busy, 0);
      @(negedge clk);
      chk("collide_still_idle", busy, 0);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int c = 0; c < 100; c++) begin
        if (busy) b++;
        d += int'(done);
        if (!busy) break;
        start = (c == 3);
        if (c == 3) clkdr = 8'd2;
        @(negedge clk);
      end
      start = 1'b0;
      chk("restart_busy_len", b, 8);
      chk("restart_done", d, 1);
      @(negedge clk);
      chk("restart_no_second", busy, 0);
    end

    // Asynchronous reset in the middle of PH2.
    mode  = 2'b10;
    clkdr = 8'd4;
    ncyc  = 6'd3;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("pre_reset_ph2_clk", spiclk, 1);
    #2 rst = 1'b1;
    #1 chk("midburst_reset_outputs", {spiclk, shift_stb, sample_stb, busy, done}, 0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("post_reset_clk_low", spiclk, 0);
    @(negedge clk);
    chk("post_reset_clk_cpol", spiclk, 1);
    run_burst('{2'b10, 8'd4, 6'd3, 16, 4, 3, 1, 8});

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/sc_spi_sclkgen.md
# sc_spi_sclkgen

Parametrised SPI serial-clock generator for the SPI protocol engine, succeeding the fixed 8-bit free-running generator. It runs a burst of a programmed number of SPI clock cycles with programmable divider width, full CPOL/CPHA support, odd-ratio division and a start/stop/done handshake. Per-edge shift and sample strobes are aligned to SRCCLK so the shifter needs no edge detection on SPICLK. It sits between the engine control FSM and the shift register.

## Interface
- DIV_W, 8: width of CLK_CLKDR; supports up to 2^DIV_W-1 SRCCLK cycles per SPI period.
- CNT_W, 6: width of CLK_NCYC; supports up to 2^CNT_W SPI cycles per burst.
- SRCCLK  in  1  the single clock; all logic on posedge.
- SYSRST  in  1  reset; asynchronous, active-high.
- CLK_START  in  1  one-cycle request to begin a burst; honoured only in IDLE.
- CLK_STOP  in  1  abort; honoured in any state.
- CLK_CLKDR  in  DIV_W  SPI period in SRCCLK cycles; values 0 and 1 are treated as 2.
- CLK_MODE  in  2  SPI mode; bit1 = CPOL, bit0 = CPHA.
- CLK_NCYC  in  CNT_W  SPI cycles per burst minus 1.
- SPICLK  out  1  serial clock, registered.
- SHIFT_STB  out  1  one-cycle pulse: launch the next data bit.
- SAMPLE_STB  out  1  one-cycle pulse: capture an input bit.
- BUSY  out  1  high from the cycle after an accepted START until the burst ends.
- DONE  out  1  one-cycle pulse when a burst completes normally.

## Operation
- States: IDLE, PH1 (active half, SPICLK = ~CPOL), PH2 (idle half, SPICLK = CPOL).
- Period and halves: D = max(CLK_CLKDR, 2). PH1 length H = floor(D/2). PH2 length D-H. For odd D, PH2 is one cycle longer.
- Latching: START in IDLE latches D, CLK_MODE and CLK_NCYC. Input changes during a burst have no effect.
- IDLE behaviour: SPICLK = live CLK_MODE[1], registered, so it has 1-cycle latency.
- Transitions:
  - IDLE -> PH1 on START & !STOP.
  - PH1 -> PH2 after H cycles.
  - PH2 -> PH1 after D-H cycles if cycles remain.
  - PH2 -> IDLE after the last cycle, pulsing DONE.
  - Any state -> IDLE on STOP.
- Edges: the leading edge is PH1 entry; the trailing edge is PH2 entry.
- CPHA=0:
  - SAMPLE_STB on every leading edge.
  - SHIFT_STB on every trailing edge except the last one.
  - The first bit is launched by the controller before START.
- CPHA=1:
  - SHIFT_STB on every leading edge.
  - SAMPLE_STB on every trailing edge.
- Counters: the phase counter is DIV_W bits and reloads on each phase entry. The cycle counter is CNT_W bits, loaded with CLK_NCYC and decremented at each PH2 exit. The burst is last when it reads 0, so there is no wrap.
- STOP during a burst:
  - Next cycle: IDLE, SPICLK = CPOL, BUSY low.
  - No DONE and no strobes in that cycle.
- Simultaneous START and STOP in IDLE: STOP wins and nothing starts.
- START while BUSY is ignored.
- Reset (asynchronous, any time, including mid-burst): all outputs go to 0 at once, state IDLE, counters 0. After release, SPICLK reaches CPOL one cycle later.

## Timing
- START sampled at posedge t. At t+1: SPICLK leading edge, BUSY=1, leading-edge strobe.
- Strobes are asserted in the same cycle SPICLK changes level.
- Burst length: exactly (CLK_NCYC+1)*D cycles of BUSY.
- DONE is asserted in the first IDLE cycle, coincident with BUSY falling.
- A new START is accepted in the DONE cycle, giving back-to-back bursts with a 1-cycle gap at CPOL level.

## Structure
- Shared package sc_spi_pkg holds:
  - the state encoding (IDLE/PH1/PH2, 2 bits);
  - CPOL_BIT=1 and CPHA_BIT=0;
  - the minimum divider constant DIV_MIN=2.
- One sub-module, sc_spi_phase_timer. It is a DIV_W-bit loadable down-counter with load value and terminal-count output, instantiated once for the phase counter.
- The FSM, cycle counter and strobe decode live in the top module.

## Test plan
- Mode 0, CLKDR=4, NCYC=7, START pulse:
  - 8 SPICLK periods of 2 high / 2 low; BUSY for 32 cycles.
  - 8 SAMPLE_STB and 7 SHIFT_STB; DONE once.
- Mode 3, CLKDR=5, NCYC=2:
  - SPICLK idles 1, low 2 / high 3 per period.
  - 3 SHIFT_STB on falling edges and 3 SAMPLE_STB on rising edges; BUSY 15 cycles.
- CLKDR=0 and CLKDR=1, mode 1, NCYC=0: each behaves as D=2, giving 1 period, BUSY 2 cycles, DONE.
- STOP in PH1 of cycle 3 (CLKDR=6, NCYC=7):
  - Next cycle IDLE, SPICLK=CPOL, BUSY=0.
  - No DONE; strobe counts match the edges already emitted.
- START+STOP together in IDLE, then START during BUSY: no burst starts on the first; the second START is ignored and the burst length is unchanged.
- SYSRST asserted mid-PH2 with asynchronous timing, then released:
  - All outputs 0 immediately.
  - SPICLK settles to CLK_MODE[1] one cycle after release.
  - A fresh START then runs a full burst.
